// File: rtl/onchip_memory_reader_if.sv
// Memory-port and streaming-source signals of the on-chip memory reader.
// The master modport is the reader; the slave modport is the memory plus the sink.
`timescale 1ns/1ps
interface onchip_memory_reader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic                clken;
  logic [DATA_W-1:0]   readdata;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;

  modport master (
    output address, chipselect, read, write, byteenable, clken, src_data, src_valid,
    input  readdata, src_ready
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, clken, src_data, src_valid,
    output readdata, src_ready
  );
endinterface

// File: rtl/onchip_memory_reader.sv
// Reads word_count consecutive words (wrapping at MEM_WORDS) from a 1-cycle-latency
// on-chip memory and streams them through a first-word-fall-through FIFO.
`timescale 1ns/1ps
module onchip_memory_reader #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_WORDS  = 3000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [15:0]       word_count_i,
  output logic              busy_o,
  output logic              done_o,
  onchip_memory_reader_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic              inflight_q;
  logic              issue;
  logic              credit_ok;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop;

  // Reserve a FIFO slot for the word still on its way back from memory.
  assign credit_ok = (count_q + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);
  assign push      = inflight_q;
  assign pop       = (count_q != '0) && bus.src_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (word_count_i != 16'd0) begin
            addr_d      = start_addr_i;
            remaining_d = word_count_i;
            state_d     = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (credit_ok) begin
          issue       = 1'b1;
          addr_d      = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (inflight_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.readdata;
  end

  assign busy_o         = (state_q == StIssue) || (state_q == StDrain);
  assign done_o         = (state_q == StDone);
  assign bus.address    = addr_q;
  assign bus.chipselect = issue;
  assign bus.read       = issue;
  assign bus.write      = 1'b0;
  assign bus.byteenable = '1;
  assign bus.clken      = 1'b1;
  assign bus.src_valid  = (count_q != '0);
  assign bus.src_data   = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_onchip_memory_reader.sv
// Scoreboard bench for onchip_memory_reader with a mem[i]=i memory model.
`timescale 1ns/1ps
module tb_onchip_memory_reader;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int cs_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_data [$];
  logic [11:0] exp_addr [$];

  onchip_memory_reader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  onchip_memory_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .word_count_i (word_count),
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: mem[i] = i, data one cycle after the issue cycle.
  always @(posedge clk) begin
    if (bus.chipselect && bus.read) bus.readdata <= 32'(bus.address);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every issued address and every accepted word against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.chipselect) begin
        cs_cnt++;
        check("read_eq_cs", 32'(bus.read), 32'd1);
        if (exp_addr.size() == 0) check("unexpected_issue", 32'(bus.address), 32'hffffffff);
        else check("address", 32'(bus.address), 32'(exp_addr.pop_front()));
      end
      if (bus.src_valid && bus.src_ready) begin
        if (exp_data.size() == 0) check("unexpected_word", bus.src_data, 32'hffffffff);
        else check("src_data", bus.src_data, exp_data.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic do_start(input logic [11:0] a, input logic [15:0] n, input bit push_exp);
    if (push_exp) begin
      for (int i = 0; i < int'(n); i++) begin
        int w;
        w = (int'(a) + i) % 3000;
        exp_addr.push_back(12'(w));
        exp_data.push_back(32'(w));
      end
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = n;
    cs_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_cs);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    else if (exp_lat >= 0) check({name, "_latency"}, 32'(cyc - start_cyc + 1), 32'(exp_lat));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    n = 0;
    while (exp_data.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_data.size()), 32'd0);
    check({name, "_issue_count"}, 32'(cs_cnt), 32'(exp_cs));
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_cs"}, 32'(bus.chipselect), 32'd0);
    check({name, "_read"}, 32'(bus.read), 32'd0);
    check({name, "_address"}, 32'(bus.address), 32'd0);
    check({name, "_src_valid"}, 32'(bus.src_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    bus.src_ready = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_write", 32'(bus.write), 32'd0);
    check("reset_byteenable", 32'(bus.byteenable), 32'hf);
    check("reset_clken", 32'(bus.clken), 32'd1);
    @(negedge clk) reset_n = 1'b1;

    // Basic transfer.
    do_start(12'd5, 16'd4, 1'b1);
    @(negedge clk);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 6, 4);

    // Address wrap.
    do_start(12'd2998, 16'd4, 1'b1);
    wait_done("wrap", 6, 4);

    // Backpressure: only FIFO_DEPTH reads may be outstanding.
    bus.src_ready = 1'b0;
    do_start(12'd100, 16'd20, 1'b1);
    repeat (30) @(negedge clk);
    check("bp_issue_stall", 32'(cs_cnt), 32'd8);
    check("bp_valid", 32'(bus.src_valid), 32'd1);
    check("bp_head_stable", bus.src_data, 32'd100);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 bus.src_ready = 1'b1;
    wait_done("bp", -1, 20);

    // Zero-length request.
    do_start(12'd7, 16'd0, 1'b1);
    check("zero_valid_early", 32'(bus.src_valid), 32'd0);
    wait_done("zero", 1, 0);
    check("zero_valid", 32'(bus.src_valid), 32'd0);

    // Reset with reads outstanding.
    bus.src_ready = 1'b0;
    do_start(12'd50, 16'd10, 1'b1);
    n = 0;
    while (cs_cnt < 3 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst_reached_3_issues", 32'(cs_cnt >= 3), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;
    bus.src_ready = 1'b1;
    do_start(12'd0, 16'd2, 1'b1);
    wait_done("restart", 4, 2);

    // Start while busy is ignored.
    do_start(12'd10, 16'd6, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'd500; word_count = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", 8, 6);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_addr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onchip_memory_reader.md
ONCHIP_MEMORY_READER -- requirements
Module: onchip_memory_reader

Interface
REQ-001 Parameter ADDR_W, default 12, is the word-address width of the memory port.
REQ-002 Parameter DATA_W, default 32, is the data width.
REQ-003 Parameter MEM_WORDS, default 3000, is the number of valid memory words; addresses wrap at this value.
REQ-004 Parameter FIFO_DEPTH, default 8 (power of 2, >=2), is the output buffer depth.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
REQ-008 start_addr  in  ADDR_W  first word address, sampled with start.
REQ-009 word_count  in  16  number of words to read, sampled with start.
REQ-010 busy  out  1  high from the cycle after an accepted start until the transfer completes.
REQ-011 done  out  1  one-cycle pulse on completion.
REQ-012 address  out  ADDR_W  memory word address.
REQ-013 chipselect  out  1  memory select; high only on issue cycles.
REQ-014 read  out  1  read strobe; equal to chipselect.
REQ-015 write  out  1  constant 0.
REQ-016 byteenable  out  DATA_W/8  constant all-ones.
REQ-017 clken  out  1  constant 1.
REQ-018 readdata  in  DATA_W  memory data, valid exactly 1 cycle after the issue cycle.
REQ-019 src_data  out  DATA_W  streamed word.
REQ-020 src_valid  out  1  src_data is valid.
REQ-021 src_ready  in  1  sink accepts the word when src_valid and src_ready are both high.

Function
REQ-022 States: IDLE, ISSUE, DRAIN, DONE; the state after reset is IDLE.
REQ-023 IDLE + start with word_count>0: latch start_addr and word_count, go to ISSUE, busy=1.
REQ-024 IDLE + start with word_count=0: go to DONE with no memory access.
REQ-025 ISSUE: issue one read per cycle while remaining>0 and (fifo_count + inflight) < FIFO_DEPTH, where inflight is 1 if a read was issued in the previous cycle.
REQ-026 Each issue: address <= current address, chipselect=read=1, current address increments, remaining decrements.
REQ-027 Address wrap: after MEM_WORDS-1 the next address is 0.
REQ-028 Each readdata capture (1 cycle after issue) is written into the FIFO; no read data is ever dropped.
REQ-029 ISSUE -> DRAIN when the last read has been issued.
REQ-030 DRAIN -> DONE once the last read data has been written into the FIFO; DONE does not wait for the FIFO to empty.
REQ-031 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-032 start outside IDLE is ignored, with no effect on the current transfer.
REQ-033 The FIFO is first-word-fall-through: src_valid = (fifo_count>0), src_data = head word.
REQ-034 A simultaneous FIFO write and pop in one cycle leaves fifo_count unchanged, and the data order is preserved.
REQ-035 src_data/src_valid hold stable while src_valid=1 and src_ready=0.
REQ-036 Word order at src equals address order: start_addr, start_addr+1, ... modulo MEM_WORDS.

Reset
REQ-037 reset_n low: state=IDLE, busy=0, done=0, chipselect=read=0, address=0, FIFO emptied, src_valid=0, inflight=0, remaining=0, all asynchronously.
REQ-038 reset_n asserted mid-transfer abandons the transfer; any in-flight readdata is discarded; no done pulse is produced.
REQ-039 After reset_n deasserts, the first start is honoured on the following rising edge.

Verification
REQ-040 Memory model with mem[i]=i; start_addr=5, word_count=4, src_ready=1 -> reads issue on 4 consecutive cycles at addresses 5,6,7,8; src emits 5,6,7,8; one done pulse; busy falls with done.
REQ-041 start_addr=2998, word_count=4, MEM_WORDS=3000 -> addresses 2998,2999,0,1; data in the same order.
REQ-042 src_ready=0, word_count=20, FIFO_DEPTH=8 -> exactly 8 reads issue, then chipselect stays low; raising src_ready resumes issue; all 20 words arrive in order with none lost or duplicated.
REQ-043 word_count=0 -> no chipselect, done pulses 1 cycle after start, src_valid stays 0.
REQ-044 reset_n pulsed low while 3 reads are outstanding -> all outputs return to reset values immediately; a new start (addr 0, count 2) delivers exactly 0,1 with no stale data.
REQ-045 start pulsed during an active transfer -> ignored; word count and data stream of the active transfer are unchanged.
